cmp_search_ctrl: RTL and testbench

Successive-approximation search controller that drives the `a` operand of the team's N-bit magnitude comparator and consumes its `l`/`e`/`h` result flags. The unknown value sits on the comparator's `b` input. The controller determines that value one bit per clock, MSB first. It is the initiator side of the compare interface: it issues trial values, reads back the flags and reports the recovered value with a `done` pulse.

---
 rtl/cmp_search_pkg.sv | 18 +
 rtl/cmp_search_ctrl_if.sv | 29 ++
 rtl/cmp_search_ctrl_dp.sv | 112 +++++++++++
 rtl/cmp_search_ctrl.sv | 118 +++++++++++
 tb/tb_cmp_search_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cmp_search_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package cmp_search_pkg;

  localparam int CMP_N_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    VERIFY = 2'd2,
    DONE   = 2'd3
  } cmp_state_e;

  // A trustworthy comparator raises exactly one of l/e/h.
  function automatic logic flags_onehot(input logic l, input logic e, input logic h);
    return (l ^ e ^ h) & ~(l & e & h);
  endfunction

endpackage

// File: rtl/cmp_search_ctrl_if.sv
// Compare-bus bundle between the search controller (master) and comparator/host side (slave).
interface cmp_search_ctrl_if
  import cmp_search_pkg::*;
#(
  parameter int N = CMP_N_DEFAULT
) ();

  logic         start;
  logic         l;
  logic         e;
  logic         h;
  logic [N-1:0] trial;
  logic [N-1:0] result;
  logic         busy;
  logic         done;
  logic         found;
  logic         err;

  modport master (
    input  start, l, e, h,
    output trial, result, busy, done, found, err
  );

  modport slave (
    output start, l, e, h,
    input  trial, result, busy, done, found, err
  );

endinterface

// File: rtl/cmp_search_ctrl_dp.sv
// Search datapath: bit index, working value, trial/result registers and status flags.
module cmp_search_ctrl_dp #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic         hit_i,
  input  logic         verify_i,
  input  logic         fault_i,
  input  logic         finish_i,
  input  logic         e_i,
  input  logic         h_i,
  output logic         last_o,
  output logic [N-1:0] trial_o,
  output logic [N-1:0] result_o,
  output logic         found_o,
  output logic         err_o,
  output logic         done_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(N - 1);

  logic [IW-1:0] idx_q, idx_d, idx_dec;
  logic [N-1:0]  trial_q, trial_d;
  logic [N-1:0]  work_q, work_d, work_upd;
  logic [N-1:0]  result_q, result_d;
  logic          found_q, found_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  assign idx_dec  = idx_q - IW'(1);
  // Bit k survives unless the trial overshot the target.
  assign work_upd = h_i ? work_q : (work_q | (N'(1) << idx_q));

  always_comb begin
    idx_d    = idx_q;
    trial_d  = trial_q;
    work_d   = work_q;
    result_d = result_q;
    found_d  = found_q;
    err_d    = err_q;
    done_d   = 1'b0;

    if (load_i) begin
      idx_d    = IDX_MSB;
      trial_d  = N'(1) << (N - 1);
      work_d   = '0;
      result_d = '0;
      found_d  = 1'b0;
      err_d    = 1'b0;
    end

    if (step_i) begin
      work_d = work_upd;
      if (hit_i || (idx_q == '0)) begin
        trial_d = work_upd;
      end else begin
        idx_d   = idx_dec;
        trial_d = work_upd | (N'(1) << idx_dec);
      end
    end

    if (hit_i) begin
      found_d = 1'b1;
    end

    if (verify_i) begin
      found_d = e_i;
    end

    if (fault_i) begin
      err_d   = 1'b1;
      found_d = 1'b0;
    end

    if (finish_i) begin
      done_d   = 1'b1;
      result_d = work_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      trial_q  <= '0;
      work_q   <= '0;
      result_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      trial_q  <= trial_d;
      work_q   <= work_d;
      result_q <= result_d;
      found_q  <= found_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign last_o   = (idx_q == '0);
  assign trial_o  = trial_q;
  assign result_o = result_q;
  assign found_o  = found_q;
  assign err_o    = err_q;
  assign done_o   = done_q;

endmodule

// File: rtl/cmp_search_ctrl.sv
// Successive-approximation search controller driving a magnitude comparator, MSB first.
// Define CMP_SEARCH_EARLY_EXIT_EN to stop probing as soon as the comparator reports equality.
//
// state  | meaning
// IDLE   | waiting for start
// PROBE  | one bit of the working value decided per cycle
// VERIFY | final trial equals working value; e confirms the match
// DONE   | latch result, raise done next cycle
module cmp_search_ctrl
  import cmp_search_pkg::*;
#(
  parameter int N = CMP_N_DEFAULT
) (
  input logic               clk,
  input logic               rst_n,
  cmp_search_ctrl_if.master bus
);

`ifdef CMP_SEARCH_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  cmp_state_e state_q, state_d;

  logic flags_ok;
  logic last;
  logic load, step, hit, verify, fault, finish;
  logic busy;

  assign flags_ok = flags_onehot(bus.l, bus.e, bus.h);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = PROBE;
        end
      end
      PROBE: begin
        if (!flags_ok || (EARLY_EXIT && bus.e)) begin
          state_d = DONE;
        end else if (last) begin
          state_d = VERIFY;
        end
      end
      VERIFY:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    hit    = 1'b0;
    verify = 1'b0;
    fault  = 1'b0;
    finish = 1'b0;
    busy   = 1'b0;
    case (state_q)
      IDLE: load = bus.start;
      PROBE: begin
        busy = 1'b1;
        if (flags_ok) begin
          step = 1'b1;
          hit  = EARLY_EXIT && bus.e;
        end else begin
          fault = 1'b1;
        end
      end
      VERIFY: begin
        busy = 1'b1;
        if (flags_ok) begin
          verify = 1'b1;
        end else begin
          fault = 1'b1;
        end
      end
      DONE:    finish = 1'b1;
      default: ;
    endcase
  end

  cmp_search_ctrl_dp #(
    .N (N)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .step_i   (step),
    .hit_i    (hit),
    .verify_i (verify),
    .fault_i  (fault),
    .finish_i (finish),
    .e_i      (bus.e),
    .h_i      (bus.h),
    .last_o   (last),
    .trial_o  (bus.trial),
    .result_o (bus.result),
    .found_o  (bus.found),
    .err_o    (bus.err),
    .done_o   (bus.done)
  );

  assign bus.busy = busy;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Self-checking bench for cmp_search_ctrl (N = 8) with a behavioural comparator and search model.
module tb_cmp_search_ctrl;

  localparam int N = 8;

`ifdef CMP_SEARCH_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] target = '0;
  logic         force_en = 1'b0;
  logic [2:0]   force_val = 3'b000;
  int           tests_run = 0;
  int           tests_failed = 0;

  logic [N-1:0] m_seq[$];
  logic [N-1:0] m_res;
  bit           m_found;
  bit           m_err;
  int           m_lat;

  typedef struct {
    logic [N-1:0] tgt;
    int           fp;
    logic [2:0]   fv;
    bit           hold;
    bit           poke;
    logic [N-1:0] exp_res;
    bit           exp_found;
    bit           exp_err;
  } vec_t;

  vec_t vecs[7];

  cmp_search_ctrl_if #(.N(N)) bus ();

  cmp_search_ctrl #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (force_en) begin
      {bus.l, bus.e, bus.h} = force_val;
    end else begin
      bus.l = (bus.trial < target);
      bus.e = (bus.trial == target);
      bus.h = (bus.trial > target);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_trial"},  32'(bus.trial),  32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_busy"},   32'(bus.busy),   32'd0);
    check({tag, "_done"},   32'(bus.done),   32'd0);
    check({tag, "_found"},  32'(bus.found),  32'd0);
    check({tag, "_err"},    32'(bus.err),    32'd0);
  endtask

  // Binary search over the target: every trial is the decided prefix plus the next bit.
  task automatic model(input logic [N-1:0] tgt, input int fp);
    logic [N-1:0] w;
    logic [N-1:0] t;
    bit           stop;
    m_seq.delete();
    w       = '0;
    m_found = 1'b0;
    m_err   = 1'b0;
    stop    = 1'b0;
    m_lat   = N + 2;
    for (int k = N - 1; k >= 0 && !stop; k--) begin
      t = w | (N'(1) << k);
      m_seq.push_back(t);
      if (m_seq.size() == fp) begin
        m_err = 1'b1;
        stop  = 1'b1;
        m_lat = m_seq.size() + 1;
      end else begin
        if (t <= tgt) w = t;
        if (EARLY && (t == tgt)) begin
          m_found = 1'b1;
          stop    = 1'b1;
          m_lat   = m_seq.size() + 1;
        end
      end
    end
    if (!stop) begin
      m_seq.push_back(w);
      if (fp == N + 1) m_err = 1'b1;
      else m_found = (w == tgt);
    end
    m_res = w;
  endtask

  task automatic run_search(input logic [N-1:0] tgt, input int fp, input logic [2:0] fv,
                            input bit hold, input bit poke, input logic [N-1:0] exp_res,
                            input bit exp_found, input bit exp_err);
    logic [N-1:0] obs[$];
    int c;
    int done_at;
    bit seen;
    model(tgt, fp);
    force_val = fv;
    @(negedge clk);
    target    = tgt;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    c       = 0;
    done_at = -1;
    if (!hold) bus.start = 1'b0;
    if (bus.busy) obs.push_back(bus.trial);
    force_en = (fp == 1);
    while (done_at < 0 && c < 4 * N) begin
      @(posedge clk);
      #1;
      c++;
      force_en = 1'b0;
      if (poke) bus.start = (c == 1);
      if (bus.done) begin
        done_at = c;
      end else if (bus.busy) begin
        obs.push_back(bus.trial);
        if (obs.size() == fp) force_en = 1'b1;
      end
    end
    if (!hold) bus.start = 1'b0;
    check("latency", 32'(done_at), 32'(m_lat));
    check("probe_count", 32'(obs.size()), 32'(m_seq.size()));
    for (int i = 0; i < obs.size() && i < m_seq.size(); i++) begin
      check($sformatf("trial[%0d]", i), 32'(obs[i]), 32'(m_seq[i]));
    end
    check("result", 32'(bus.result), 32'(exp_res));
    check("found",  32'(bus.found),  32'(exp_found));
    check("err",    32'(bus.err),    32'(exp_err));
    @(posedge clk);
    #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    check("relaunch_busy", 32'(bus.busy), 32'(hold));
    if (!hold) begin
      check("result_held", 32'(bus.result), 32'(exp_res));
    end else begin
      bus.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4 * N && !seen; i++) begin
        @(posedge clk);
        #1;
        seen = bus.done;
      end
      check("relaunch_done", 32'(seen), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] tgt;
    int           fp;
    logic [2:0]   fv;
    bit           poke;

    vecs[0] = '{8'd200, 0, 3'b000, 1'b0, 1'b0, 8'd200, 1'b1, 1'b0};
    vecs[1] = '{8'd0,   0, 3'b000, 1'b0, 1'b0, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{8'd255, 0, 3'b000, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0};
    vecs[3] = '{8'd200, 3, 3'b000, 1'b0, 1'b1, 8'd192, 1'b0, 1'b1};
    vecs[4] = '{8'd0,   9, 3'b111, 1'b0, 1'b0, 8'd0,   1'b0, 1'b1};
    vecs[5] = '{8'd128, 0, 3'b000, 1'b1, 1'b0, 8'd128, 1'b1, 1'b0};
    vecs[6] = '{8'd1,   0, 3'b000, 1'b0, 1'b0, 8'd1,   1'b1, 1'b0};

    bus.start = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_search(vecs[i].tgt, vecs[i].fp, vecs[i].fv, vecs[i].hold, vecs[i].poke,
                 vecs[i].exp_res, vecs[i].exp_found, vecs[i].exp_err);
    end

    // Asynchronous reset in the middle of a search.
    @(negedge clk);
    target    = 8'd200;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 32'(bus.busy), 32'd0);
    run_search(8'd200, 0, 3'b000, 1'b0, 1'b0, 8'd200, 1'b1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      tgt = N'($urandom_range(0, 255));
      fp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N + 1)) : 0;
      do begin
        fv = 3'($urandom_range(0, 7));
      end while ($countones(fv) == 1);
      poke = 1'($urandom_range(0, 1));
      model(tgt, fp);
      run_search(tgt, fp, fv, 1'b0, poke, m_res, m_found, m_err);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
